seq_overlap_resolver: RTL and testbench
=======================================

// Module: seq_overlap_resolver
// PURPOSE
//  Sits directly downstream of a job_pe seq port, before the seq encoder.
//  Removes bytes that the previous job's final match already covers: it trims ll/ml of following seqs by the carried overlap_len.
//  It drops seqs that are fully covered and folds sub-minimum match remnants into a literal carry.
//  It emits a clean seq stream (ll, ml, offset, delim) with valid/ready and one registered output stage.
// PARAMETERS
//  MIN_MATCH_LEN   3   smallest ml allowed on output; a shorter trimmed remnant becomes literals
//  STAT_CNT_WIDTH  32  width of the statistics counters (used only with SEQ_OVERLAP_STAT_EN)
//  Field widths come from `SEQ_LL_BITS, `SEQ_ML_BITS and `SEQ_OFFSET_BITS in parameters.vh.
// PORTS
//  clk              in   1    clock
//  rst              in   1    synchronous reset, active-high
//  in_seq_valid     in   1    input seq valid
//  in_seq_ll        in   LL   literal length
//  in_seq_ml        in   ML   match length (0 = literal-only tail)
//  in_seq_offset    in   OFF  match offset
//  in_seq_eoj       in   1    last seq of a job
//  in_seq_overlap_len in ML   bytes the match extends past the job end (meaningful only when eoj=1)
//  in_seq_delim     in   1    block delimiter; overlap never crosses it
//  in_seq_ready     out  1    input accepted when valid && ready
//  out_seq_valid/ll/ml/offset/delim  out  1/LL/ML/OFF/1  resolved seq
//  out_seq_ready    in   1    downstream ready
//  stat_drop_cnt    out  STAT_CNT_WIDTH  seqs fully absorbed     [SEQ_OVERLAP_STAT_EN only]
//  stat_trim_bytes  out  STAT_CNT_WIDTH  bytes trimmed in total  [SEQ_OVERLAP_STAT_EN only]
// BEHAVIOUR
//  State registers:
//   - ovl_reg (ML bits): remaining overlap.
//   - carry_reg (LL bits): folded literals.
//   - Output register.
//  Modes:
//   - S_PASS when ovl_reg==0.
//   - S_TRIM otherwise.
//  Reset values:
//   - ovl_reg=0, carry_reg=0.
//   - out_seq_valid=0 and all out fields 0; statistics counters 0.
//  Handshake:
//   - in_seq_ready = !out_seq_valid || out_seq_ready. This is a single output stage with 1-cycle latency and no bubble under full throughput.
//   - Output fields stay stable while valid && !ready.
//  On accept, with r = ovl_reg, L = ll, M = ml:
//   - r==0: emit ll=L+carry, ml=M, offset unchanged; carry<=0.
//   - r<=L: emit ll=L-r+carry, ml=M; ovl<=0; carry<=0.
//   - r>L and r-L < M:
//     - Let m' = M-(r-L).
//     - If m' >= MIN_MATCH_LEN: emit ll=carry, ml=m'; carry<=0.
//     - Otherwise: no emit; carry<=carry+m'.
//     - In both cases ovl<=0.
//   - r >= L+M (fully covered): no emit; ovl<=r-L-M; stat_drop_cnt++.
//  On eoj=1 and delim=0 (applied after the above):
//   - ovl <= max(remaining ovl, in_seq_overlap_len).
//   - Both values are measured from the same job end.
//  On delim=1:
//   - ovl<=0.
//   - If the seq produced no emit, emit a literal-only seq (ll=carry, ml=0, offset=0, delim=1), so a delim is never lost.
//   - carry<=0 after any delim emit.
//   - A delim seq with ml=0 always emits, with ll=L-trim+carry (floored at 0).
//  Widths:
//   - All subtracts are guarded by compares, so nothing underflows.
//   - carry_reg is LL bits; the sum with ll must fit LL bits (guaranteed by job length). A simulation assertion fires on overflow.
//  Boundaries:
//   - Back-to-back fully covered seqs spanning a whole job accumulate through the max rule.
//   - ovl that equals exactly L+M is fully covered and yields no zero-length emit.
//   - Reset mid-stream discards ovl, carry and the output stage immediately.
// CONFIGURATION
//  SEQ_OVERLAP_STAT_EN defined:
//   - The stat_* ports and counters exist.
//   - stat_trim_bytes adds min(r, L+M) on each accept with r>0.
//   - Counters wrap modulo 2^STAT_CNT_WIDTH.
//  SEQ_OVERLAP_STAT_EN undefined: no stat ports or counters; all other behaviour is identical.
// STRUCTURE
//  - seq_pkg / parameters.vh holds `SEQ_* widths, MIN_MATCH_LEN and a seq field-bundle macro.
//  - One sub-module, seq_trim_calc: purely combinational. It takes (r, L, M, carry) and returns (emit, ll, ml, new_r, new_carry, trimmed).
//  - The top holds the registers, the handshake and the delim/eoj rules.
// TESTING
//  1. Pass-through: ovl=0; seqs (5,10,off 100) then (3,4,off 8) -> identical outputs, 1-cycle latency.
//  2. Literal trim: eoj seq with overlap_len=6; next seq (10,8) -> out (4,8); ovl back to 0.
//  3. Match trim and fold:
//     - overlap 12; next (4,10) -> out (0,2)? No: m'=2<3, so no emit, carry=2.
//     - Then (5,7) -> out (7,7).
//  4. Full cover: overlap 40; seqs (3,5), (2,4) dropped -> ovl=26; an eoj seq with overlap_len 30 -> ovl=30; stat_drop_cnt=2.
//  5. Delim: overlap 9, then (2,3,delim=1) fully covered -> out (0,0,delim=1); next job starts with ovl=0.
//  6. Backpressure plus reset:
//     - out_seq_ready low 5 cycles -> output held stable and in_seq_ready=0.
//     - rst mid-trim -> out_seq_valid=0 and ovl=0 in the next cycle.

Source files
------------

// File: rtl/seq_overlap_resolver_pkg.sv
// seq_overlap_resolver_pkg: shared seq field widths, types and helpers.
// The field widths default to 16/16/16 bits unless the SEQ_*_BITS macros
// are defined before this file is compiled.

`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 16
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 16
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

package seq_overlap_resolver_pkg;

    localparam int unsigned LL_W  = `SEQ_LL_BITS;
    localparam int unsigned ML_W  = `SEQ_ML_BITS;
    localparam int unsigned OFF_W = `SEQ_OFFSET_BITS;

    localparam int unsigned MIN_MATCH_LEN_DEFAULT = 3;

    typedef logic [LL_W-1:0]  ll_t;
    typedef logic [ML_W-1:0]  ml_t;
    typedef logic [OFF_W-1:0] off_t;

    // One resolved seq as held in the output stage
    typedef struct packed {
        ll_t  ll;
        ml_t  ml;
        off_t offset;
        logic delim;
    } seq_t;

    function automatic ml_t ml_max(input ml_t a, input ml_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_overlap_resolver_if.sv
// seq_overlap_resolver_if: input and output seq streams of the resolver.
// slave is the resolver side, master is the upstream/downstream side.

interface seq_overlap_resolver_if;
    import seq_overlap_resolver_pkg::*;

    logic in_seq_valid;
    ll_t  in_seq_ll;
    ml_t  in_seq_ml;
    off_t in_seq_offset;
    logic in_seq_eoj;
    ml_t  in_seq_overlap_len;
    logic in_seq_delim;
    logic in_seq_ready;

    logic out_seq_valid;
    ll_t  out_seq_ll;
    ml_t  out_seq_ml;
    off_t out_seq_offset;
    logic out_seq_delim;
    logic out_seq_ready;

    modport slave (
        input  in_seq_valid,
        input  in_seq_ll,
        input  in_seq_ml,
        input  in_seq_offset,
        input  in_seq_eoj,
        input  in_seq_overlap_len,
        input  in_seq_delim,
        output in_seq_ready,
        output out_seq_valid,
        output out_seq_ll,
        output out_seq_ml,
        output out_seq_offset,
        output out_seq_delim,
        input  out_seq_ready
    );

    modport master (
        output in_seq_valid,
        output in_seq_ll,
        output in_seq_ml,
        output in_seq_offset,
        output in_seq_eoj,
        output in_seq_overlap_len,
        output in_seq_delim,
        input  in_seq_ready,
        input  out_seq_valid,
        input  out_seq_ll,
        input  out_seq_ml,
        input  out_seq_offset,
        input  out_seq_delim,
        output out_seq_ready
    );

endinterface

// File: rtl/seq_overlap_resolver_trim_calc.sv
// seq_trim_calc: purely combinational trim of one seq against the carried
// overlap r and literal carry. All arithmetic runs in a widened type so
// every subtract is guarded by its compare and sums cannot wrap silently.

module seq_trim_calc
    import seq_overlap_resolver_pkg::*;
#(
    parameter int unsigned MIN_MATCH_LEN = MIN_MATCH_LEN_DEFAULT
)
(
    input  ml_t  r,
    input  ll_t  l,
    input  ml_t  m,
    input  ll_t  carry,
    output logic emit,
    output ll_t  ll_out,
    output ml_t  ml_out,
    output ml_t  new_r,
    output ll_t  new_carry,
    output ml_t  trimmed,
    output logic drop,
    output logic ll_ovf
);

    localparam int unsigned W = ((LL_W > ML_W) ? LL_W : ML_W) + 2;
    typedef logic [W-1:0] wide_t;

    wide_t r_w;
    wide_t l_w;
    wide_t m_w;
    wide_t c_w;
    wide_t lm_w;
    wide_t m_rem;
    wide_t sum;

    // Select one of the four coverage cases and build the trimmed seq
    always_comb begin
        r_w       = wide_t'(r);
        l_w       = wide_t'(l);
        m_w       = wide_t'(m);
        c_w       = wide_t'(carry);
        lm_w      = l_w + m_w;
        m_rem     = '0;
        sum       = '0;
        emit      = 1'b0;
        ml_out    = '0;
        new_r     = '0;
        new_carry = '0;
        trimmed   = '0;
        drop      = 1'b0;

        if (r_w == '0) begin
            emit   = 1'b1;
            sum    = l_w + c_w;
            ml_out = m;
        end else if (r_w <= l_w) begin
            emit    = 1'b1;
            sum     = l_w - r_w + c_w;
            ml_out  = m;
            trimmed = r;
        end else if (r_w < lm_w) begin
            m_rem   = m_w - (r_w - l_w);
            trimmed = r;
            if (m_rem >= wide_t'(MIN_MATCH_LEN)) begin
                emit   = 1'b1;
                sum    = c_w;
                ml_out = ml_t'(m_rem);
            end else begin
                sum       = c_w + m_rem;
                new_carry = ll_t'(sum);
            end
        end else begin
            new_r     = ml_t'(r_w - lm_w);
            new_carry = carry;
            trimmed   = ml_t'(lm_w);
            drop      = 1'b1;
            sum       = c_w;
        end

        ll_out = emit ? ll_t'(sum) : '0;
        ll_ovf = |sum[W-1:LL_W];
    end

endmodule

// File: rtl/seq_overlap_resolver.sv
// seq_overlap_resolver: trims seqs already covered by the previous job's
// final match, folds short match remnants into literals and emits a clean
// seq stream through one registered output stage.
// Optional feature macro: SEQ_OVERLAP_STAT_EN adds the stat_* counters.

module seq_overlap_resolver
    import seq_overlap_resolver_pkg::*;
#(
    parameter int unsigned MIN_MATCH_LEN = MIN_MATCH_LEN_DEFAULT
`ifdef SEQ_OVERLAP_STAT_EN
    , parameter int unsigned STAT_CNT_WIDTH = 32
`endif
)
(
    input logic clk,
    input logic rst,
    seq_overlap_resolver_if.slave bus
`ifdef SEQ_OVERLAP_STAT_EN
    , output logic [STAT_CNT_WIDTH-1:0] stat_drop_cnt
    , output logic [STAT_CNT_WIDTH-1:0] stat_trim_bytes
`endif
);

    localparam logic [0:0] S_PASS = 1'b0;
    localparam logic [0:0] S_TRIM = 1'b1;

    ml_t        ovl_reg;
    ll_t        carry_reg;
    seq_t       out_reg;
    logic       out_valid;
    logic [0:0] mode;

    logic in_ready;
    logic accept;

    logic calc_emit;
    ll_t  calc_ll;
    ml_t  calc_ml;
    ml_t  calc_new_r;
    ll_t  calc_new_carry;
    ml_t  calc_trimmed;
    logic calc_drop;
    logic calc_ll_ovf;

    logic nxt_emit;
    ml_t  nxt_ovl;
    ll_t  nxt_carry;
    seq_t nxt_seq;

    assign mode     = (ovl_reg == '0) ? S_PASS : S_TRIM;
    assign in_ready = !out_valid || bus.out_seq_ready;
    assign accept   = bus.in_seq_valid && in_ready;

    assign bus.in_seq_ready   = in_ready;
    assign bus.out_seq_valid  = out_valid;
    assign bus.out_seq_ll     = out_reg.ll;
    assign bus.out_seq_ml     = out_reg.ml;
    assign bus.out_seq_offset = out_reg.offset;
    assign bus.out_seq_delim  = out_reg.delim;

    seq_trim_calc #(
        .MIN_MATCH_LEN (MIN_MATCH_LEN)
    ) u_trim_calc (
        .r         (ovl_reg),
        .l         (bus.in_seq_ll),
        .m         (bus.in_seq_ml),
        .carry     (carry_reg),
        .emit      (calc_emit),
        .ll_out    (calc_ll),
        .ml_out    (calc_ml),
        .new_r     (calc_new_r),
        .new_carry (calc_new_carry),
        .trimmed   (calc_trimmed),
        .drop      (calc_drop),
        .ll_ovf    (calc_ll_ovf)
    );

    // Apply the eoj overlap merge and the delim rules on top of the trim result;
    // a delim seq that the trim swallowed still leaves as a literal-only seq
    always_comb begin
        nxt_emit       = calc_emit;
        nxt_ovl        = (mode == S_TRIM) ? calc_new_r : '0;
        nxt_carry      = calc_new_carry;
        nxt_seq.ll     = calc_ll;
        nxt_seq.ml     = calc_ml;
        nxt_seq.offset = bus.in_seq_offset;
        nxt_seq.delim  = bus.in_seq_delim;

        if (bus.in_seq_eoj && !bus.in_seq_delim) begin
            nxt_ovl = ml_max(nxt_ovl, bus.in_seq_overlap_len);
        end

        if (bus.in_seq_delim) begin
            nxt_ovl   = '0;
            nxt_carry = '0;
            if (!calc_emit) begin
                nxt_emit       = 1'b1;
                nxt_seq.ll     = calc_new_carry;
                nxt_seq.ml     = '0;
                nxt_seq.offset = '0;
                nxt_seq.delim  = 1'b1;
            end
        end
    end

    // Overlap/carry state and the single output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            ovl_reg   <= '0;
            carry_reg <= '0;
            out_valid <= 1'b0;
            out_reg   <= '0;
        end else begin
            if (accept) begin
                ovl_reg   <= nxt_ovl;
                carry_reg <= nxt_carry;
            end
            if (in_ready) begin
                out_valid <= accept && nxt_emit;
                if (accept && nxt_emit) begin
                    out_reg <= nxt_seq;
                end
            end
        end
    end

    // Literal length plus carry must fit the ll field
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            assert (!calc_ll_ovf);
        end
    end

`ifdef SEQ_OVERLAP_STAT_EN
    // Dropped-seq and trimmed-byte counters, wrapping at full width
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_drop_cnt   <= '0;
            stat_trim_bytes <= '0;
        end else if (accept) begin
            if (calc_drop) begin
                stat_drop_cnt <= stat_drop_cnt + 1'b1;
            end
            if (mode == S_TRIM) begin
                stat_trim_bytes <= stat_trim_bytes + STAT_CNT_WIDTH'(calc_trimmed);
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_overlap_resolver.sv
// tb_seq_overlap_resolver: directed vectors with hand-computed results.

module tb_seq_overlap_resolver;
    import seq_overlap_resolver_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    seq_overlap_resolver_if bus();

`ifdef SEQ_OVERLAP_STAT_EN
    logic [31:0] stat_drop_cnt;
    logic [31:0] stat_trim_bytes;
    logic [31:0] stat_snap;
`endif

    always #5 clk = ~clk;

    seq_overlap_resolver #(
        .MIN_MATCH_LEN (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus)
`ifdef SEQ_OVERLAP_STAT_EN
        , .stat_drop_cnt   (stat_drop_cnt)
        , .stat_trim_bytes (stat_trim_bytes)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.in_seq_valid       = 1'b0;
        bus.in_seq_ll          = '0;
        bus.in_seq_ml          = '0;
        bus.in_seq_offset      = '0;
        bus.in_seq_eoj         = 1'b0;
        bus.in_seq_overlap_len = '0;
        bus.in_seq_delim       = 1'b0;
    endtask

    task automatic drive_seq(input int ll, input int ml, input int off,
                             input bit eoj, input int olen, input bit delim);
        bus.in_seq_valid       = 1'b1;
        bus.in_seq_ll          = ll_t'(ll);
        bus.in_seq_ml          = ml_t'(ml);
        bus.in_seq_offset      = off_t'(off);
        bus.in_seq_eoj         = eoj;
        bus.in_seq_overlap_len = ml_t'(olen);
        bus.in_seq_delim       = delim;
    endtask

    // Presents one seq, waits (bounded) for acceptance, returns 1ns after the accepting edge
    task automatic send(input int ll, input int ml, input int off,
                        input bit eoj, input int olen, input bit delim);
        int unsigned waited = 0;
        drive_seq(ll, ml, off, eoj, olen, delim);
        @(negedge clk);
        while (!bus.in_seq_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("accept", bus.in_seq_ready, 1);
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic expect_out(input string tag, input int ll, input int ml,
                              input int off, input bit delim);
        check_eq({tag, ".valid"}, bus.out_seq_valid, 1);
        check_eq({tag, ".ll"}, bus.out_seq_ll, ll);
        check_eq({tag, ".ml"}, bus.out_seq_ml, ml);
        check_eq({tag, ".off"}, bus.out_seq_offset, off);
        check_eq({tag, ".delim"}, bus.out_seq_delim, delim);
    endtask

    task automatic expect_none(input string tag);
        check_eq({tag, ".valid"}, bus.out_seq_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.out_seq_ready = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.valid", bus.out_seq_valid, 0);
        check_eq("rst.ll", bus.out_seq_ll, 0);
        check_eq("rst.ml", bus.out_seq_ml, 0);
        check_eq("rst.off", bus.out_seq_offset, 0);
        check_eq("rst.in_ready", bus.in_seq_ready, 1);
`ifdef SEQ_OVERLAP_STAT_EN
        check_eq("rst.drop", stat_drop_cnt, 0);
        check_eq("rst.trim", stat_trim_bytes, 0);
`endif
        rst = 1'b0;

        // Pass-through, output one cycle after acceptance
        send(5, 10, 100, 0, 0, 0);  expect_out("pass1", 5, 10, 100, 0);
        send(3, 4, 8, 0, 0, 0);     expect_out("pass2", 3, 4, 8, 0);

        // Literal trim by overlap 6
        send(2, 5, 7, 1, 6, 0);     expect_out("lt.eoj", 2, 5, 7, 0);
`ifdef SEQ_OVERLAP_STAT_EN
        stat_snap = stat_trim_bytes;
`endif
        send(10, 8, 20, 0, 0, 0);   expect_out("lt.trim", 4, 8, 20, 0);
`ifdef SEQ_OVERLAP_STAT_EN
        check_eq("lt.stat_trim", stat_trim_bytes - stat_snap, 6);
`endif
        send(1, 3, 2, 0, 0, 0);     expect_out("lt.after", 1, 3, 2, 0);

        // Match trim leaving 2 < MIN: folded into carry, then added to next ll
        send(0, 4, 1, 1, 12, 0);    expect_out("fold.eoj", 0, 4, 1, 0);
        send(4, 10, 50, 0, 0, 0);   expect_none("fold.drop");
        send(5, 7, 60, 0, 0, 0);    expect_out("fold.carry", 7, 7, 60, 0);

        // Remnant exactly MIN is emitted as a match
        send(0, 4, 1, 1, 11, 0);    expect_out("min.eoj", 0, 4, 1, 0);
        send(4, 10, 70, 0, 0, 0);   expect_out("min.emit", 0, 3, 70, 0);

        // Full cover: 40 -> 32 -> 26, eoj merge to 30
        send(1, 4, 5, 1, 40, 0);    expect_out("fc.eoj", 1, 4, 5, 0);
`ifdef SEQ_OVERLAP_STAT_EN
        stat_snap = stat_drop_cnt;
`endif
        send(3, 5, 6, 0, 0, 0);     expect_none("fc.drop1");
        send(2, 4, 7, 0, 0, 0);     expect_none("fc.drop2");
        send(30, 5, 8, 1, 30, 0);   expect_out("fc.merge", 4, 5, 8, 0);
`ifdef SEQ_OVERLAP_STAT_EN
        check_eq("fc.stat_drop", stat_drop_cnt - stat_snap, 2);
`endif
        send(31, 6, 9, 0, 0, 0);    expect_out("fc.ovl30", 1, 6, 9, 0);

        // Fully covered eoj seq keeps the larger remaining overlap (30 > 10)
        send(0, 3, 1, 1, 40, 0);    expect_out("mx.eoj", 0, 3, 1, 0);
        send(5, 5, 2, 1, 10, 0);    expect_none("mx.drop");
        send(32, 3, 4, 0, 0, 0);    expect_out("mx.keep", 2, 3, 4, 0);

        // Overlap exactly L+M: dropped, no zero-length emit
        send(0, 3, 1, 1, 7, 0);     expect_out("ex.eoj", 0, 3, 1, 0);
        send(3, 4, 2, 0, 0, 0);     expect_none("ex.drop");
        send(2, 3, 5, 0, 0, 0);     expect_out("ex.after", 2, 3, 5, 0);

        // Delim: fully covered delim seq still emits a literal-only delim
        send(1, 3, 4, 1, 9, 0);     expect_out("dl.eoj", 1, 3, 4, 0);
        send(2, 3, 11, 0, 0, 1);    expect_out("dl.cover", 0, 0, 0, 1);
        send(6, 3, 12, 0, 0, 0);    expect_out("dl.after", 6, 3, 12, 0);

        // eoj on a delim seq carries no overlap
        send(2, 4, 3, 1, 20, 1);    expect_out("dl.eojd", 2, 4, 3, 1);
        send(5, 3, 1, 0, 0, 0);     expect_out("dl.noovl", 5, 3, 1, 0);

        // Folded remnant flushed by a delim, carry cleared afterwards
        send(0, 4, 1, 1, 12, 0);    expect_out("df.eoj", 0, 4, 1, 0);
        send(4, 10, 50, 0, 0, 1);   expect_out("df.flush", 2, 0, 0, 1);
        send(3, 3, 9, 0, 0, 0);     expect_out("df.after", 3, 3, 9, 0);

        // Literal-only delim seqs: partial trim and trim past L
        send(0, 3, 1, 1, 4, 0);     expect_out("dz.eoj1", 0, 3, 1, 0);
        send(6, 0, 0, 0, 0, 1);     expect_out("dz.part", 2, 0, 0, 1);
        send(0, 3, 1, 1, 9, 0);     expect_out("dz.eoj2", 0, 3, 1, 0);
        send(6, 0, 5, 0, 0, 1);     expect_out("dz.floor", 0, 0, 0, 1);

        // Backpressure: output held, input stalled
        send(7, 8, 33, 0, 0, 0);    expect_out("bp.first", 7, 8, 33, 0);
        bus.out_seq_ready = 1'b0;
        drive_seq(1, 3, 44, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp.in_ready", bus.in_seq_ready, 0);
            check_eq("bp.valid", bus.out_seq_valid, 1);
            check_eq("bp.ll", bus.out_seq_ll, 7);
            check_eq("bp.ml", bus.out_seq_ml, 8);
            check_eq("bp.off", bus.out_seq_offset, 33);
        end
        bus.out_seq_ready = 1'b1;
        @(negedge clk);
        check_eq("bp.release", bus.in_seq_ready, 1);
        @(posedge clk);
        #1;
        drive_idle();
        expect_out("bp.next", 1, 3, 44, 0);

        // Reset mid-trim with carry and overlap pending and a seq on the input
        send(0, 4, 1, 1, 12, 0);    expect_out("rs.eoj", 0, 4, 1, 0);
        send(4, 10, 50, 1, 20, 0);  expect_none("rs.fold");
        drive_seq(30, 3, 5, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive_idle();
        check_eq("rs.valid", bus.out_seq_valid, 0);
        check_eq("rs.ll", bus.out_seq_ll, 0);
        rst = 1'b0;
        send(4, 3, 9, 0, 0, 0);     expect_out("rs.after", 4, 3, 9, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
